// File: rtl/bus_initiator.sv
// Head-end initiator for the daisy-chained register bus.
// Launches one transaction at a time and waits for it to return at the chain tail.
module bus_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    input  logic        req_rw_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [15:0] resp_addr_o,
    output logic [15:0] resp_rdata_o,
    output logic        resp_rw_o,
    output logic        resp_timeout_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  stray_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t      state;
    logic [15:0] timer;
    logic        live;
    logic        match;
    logic        stray;
    logic        unused_ok;

    assign unused_ok = ^wdata_i;
    assign rdata_o   = '0;

    // The latched head fields double as the compare key for the return.
    always_comb begin
        live  = (state == S_ISSUE) || (state == S_WAIT);
        match = valid_i && (addr_i == addr_o) && (rw_i == rw_o);
        stray = valid_i && !(live && match);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            timer          <= '0;
            req_ready_o    <= 1'b1;
            resp_addr_o    <= '0;
            resp_rdata_o   <= '0;
            resp_rw_o      <= 1'b0;
            resp_timeout_o <= 1'b0;
            resp_valid_o   <= 1'b0;
            addr_o         <= '0;
            wdata_o        <= '0;
            rw_o           <= 1'b0;
            valid_o        <= 1'b0;
            stray_count_o  <= '0;
        end else begin
            if (stray && stray_count_o != 8'hFF)
                stray_count_o <= stray_count_o + 8'd1;

            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_o      <= req_addr_i;
                        wdata_o     <= req_wdata_i;
                        rw_o        <= req_rw_i;
                        valid_o     <= 1'b1;
                        req_ready_o <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    valid_o <= 1'b0;
                    timer   <= (state == S_ISSUE) ? '0 : timer + 16'd1;
                    // A match beats a timeout landing in the same cycle.
                    if (match) begin
                        resp_addr_o    <= addr_o;
                        resp_rw_o      <= rw_o;
                        resp_rdata_o   <= rw_o ? 16'h0 : rdata_i;
                        resp_timeout_o <= 1'b0;
                        resp_valid_o   <= 1'b1;
                        state          <= S_RESP;
                    end else if (state == S_WAIT && timer == TMO) begin
                        resp_addr_o    <= addr_o;
                        resp_rw_o      <= rw_o;
                        resp_rdata_o   <= 16'h0;
                        resp_timeout_o <= 1'b1;
                        resp_valid_o   <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Head-end initiator for the daisy-chained 16-bit register bus (addr/wdata/rdata/rw/valid), whose responder cores each register and forward every field one stage per core.
- Accepts one host request at a time through a valid/ready handshake and launches a single-cycle bus transaction into the chain head.
- Watches the chain tail for the matching returning transaction and presents the response (read data, or a timeout flag) through a valid/ready handshake.
- Sits between the host-side command decoder and the first core in the chain.

Parameters:
- TIMEOUT, 255, cycles spent in WAIT without a matching return before the response is flagged as timed out; legal range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_addr_i  in  16  request address
- req_wdata_i  in  16  request write data
- req_rw_i  in  1  1 = write, 0 = read
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- resp_addr_o  out  16  address of the completed transaction
- resp_rdata_o  out  16  read data; 0 for writes and timeouts
- resp_rw_o  out  1  rw of the completed transaction
- resp_timeout_o  out  1  response produced by timeout
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when high together with resp_valid_o
- addr_o  out  16  chain head address
- wdata_o  out  16  chain head write data
- rdata_o  out  16  chain head read data, always 0
- rw_o  out  1  chain head rw
- valid_o  out  1  chain head valid
- addr_i  in  16  chain tail address
- wdata_i  in  16  chain tail write data (ignored)
- rdata_i  in  16  chain tail read data
- rw_i  in  1  chain tail rw
- valid_i  in  1  chain tail valid
- stray_count_o  out  8  saturating count of unmatched tail returns

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: all outputs are 0, except req_ready_o = 1. State = IDLE, timer = 0.
- Reset mid-transaction: reset at any point (ISSUE, WAIT or RESP) discards the transaction. No response is emitted afterwards, and any later return of that transaction counts as stray.
- States:
  - IDLE:
    - req_ready_o = 1.
    - On req_valid_i & req_ready_o, latch addr, wdata and rw, then go to ISSUE.
  - ISSUE:
    - Entered one cycle after acceptance. Lasts exactly one cycle.
    - valid_o = 1 with the latched addr_o/wdata_o/rw_o; rdata_o = 0.
    - Timer is cleared. Go to WAIT.
    - The match check is already active in this cycle, so a zero-stage (combinational) chain is supported.
  - WAIT:
    - valid_o = 0; addr_o/wdata_o/rw_o hold their last values.
    - Timer increments each cycle.
    - Match: valid_i & (addr_i == latched addr) & (rw_i == latched rw).
    - On match, capture rdata_i (forced to 0 when rw = 1), set timeout = 0, go to RESP.
    - If timer == TIMEOUT with no match in that cycle, set rdata = 0, timeout = 1, go to RESP.
    - If match and timeout occur in the same cycle, the match wins.
  - RESP:
    - resp_valid_o = 1. resp_* outputs are stable until the handshake completes.
    - On resp_ready_i, go to IDLE.
    - resp_valid_o drops the next cycle and req_ready_o rises the same next cycle.
- req_ready_o is 0 in ISSUE, WAIT and RESP, so at most one transaction is outstanding.
- Minimum latency, for a chain of N register stages with resp_ready_i held high:
  - valid_o rises 1 cycle after acceptance.
  - resp_valid_o rises N+1 cycles after valid_o.
- Stray returns:
  - Any valid_i that is not a match is a stray. This includes valid_i in IDLE or RESP, a returning transaction after a timeout, and a mismatched addr or rw in WAIT.
  - Each stray increments stray_count_o. The counter saturates at 255 and is cleared only by rst.
- Chain input fields are sampled only when valid_i = 1.

Test Plan:
- Write, 3-stage registered loopback chain: req addr=0x0012 wdata=0xBEEF rw=1 -> valid_o pulses exactly 1 cycle with addr_o=0x0012 wdata_o=0xBEEF rdata_o=0; resp_valid_o rises 4 cycles after valid_o; resp_rdata_o=0, resp_timeout_o=0.
- Read, chain model returning rdata=0x1234 for addr=0x0005 -> resp_addr_o=0x0005, resp_rdata_o=0x1234, resp_rw_o=0; req_ready_o stays low from acceptance until the cycle after the resp handshake.
- Timeout, TIMEOUT=10, chain never returns -> resp_valid_o with resp_timeout_o=1, resp_rdata_o=0; a later return of that transaction increments stray_count_o 0→1.
- Backpressure: resp_ready_i held low for 20 cycles -> resp_* stable, a concurrently presented req_valid_i is not accepted; after resp_ready_i rises, a back-to-back request is accepted the cycle after the handshake.
- Stray and saturation: 300 tail valid_i pulses while IDLE -> stray_count_o saturates at 255 and valid_o never asserts; a same-cycle mismatched addr during WAIT also counts as stray and does not complete the transaction.
- Reset mid-WAIT: rst asserted for 1 cycle -> req_ready_o=1 and resp_valid_o=0 the next cycle, and the late return increments stray_count_o.
